// File: rtl/paddle_ctrl.sv
// Paddle position controller: synchronises and debounces up/down buttons, steps the
// paddle on a periodic tick with clamping, freezes on game_over. Optional: PADDLE_ACCEL_EN.
module paddle_ctrl #(
  parameter int CLK_DIV         = 250000,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCREEN_H        = 480,
  parameter int PADDLE_H        = 48,
  parameter int STEP            = 4,
  parameter int RESET_Y         = 216,
  parameter int ACCEL_TICKS     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       game_over,
  output logic [9:0] paddle_y,
  output logic       moving,
  output logic       at_top,
  output logic       at_bottom
);

  localparam int MAX_Y = SCREEN_H - PADDLE_H;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TK_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (STEP < 1 || RESET_Y > MAX_Y || ACCEL_TICKS < 1) begin : g_bad_params
    $error("paddle_ctrl: STEP, RESET_Y or ACCEL_TICKS out of range");
  end

  typedef enum logic [1:0] {IDLE, UP, DOWN, FROZEN} state_t;

  state_t                  state, state_next;
  logic [1:0]              btn_raw, btn_meta, btn_sync, level, level_next;
  logic [1:0][DB_W-1:0]    db_cnt;
  logic [TK_W-1:0]         tick_cnt;
  logic                    tick;
  logic [10:0]             step_sz;
  logic [10:0]             sum_down;
  logic [9:0]              y_up, y_down;

  // Bit 0 is the up button, bit 1 the down button.
  assign btn_raw = {btn_down, btn_up};

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    level_next = level;
    for (int i = 0; i < 2; i++) begin
      if (btn_sync[i] != level[i] && db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1))
        level_next[i] = ~level[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_meta <= '0;
      btn_sync <= '0;
      level    <= '0;
      db_cnt   <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_sync <= btn_meta;
      level    <= level_next;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == level[i] || level_next[i] != level[i])
          db_cnt[i] <= '0;
        else
          db_cnt[i] <= db_cnt[i] + 1'b1;
      end
    end
  end

  assign tick = (tick_cnt == TK_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // The FSM looks at the debounced level as it is being updated, so the state
  // follows a press on the same edge that the debouncer accepts it.
  always_comb begin
    state_next = state;
    if (game_over)                        state_next = FROZEN;
    else if (state == FROZEN)             state_next = IDLE;
    else if (level_next == 2'b01)         state_next = UP;
    else if (level_next == 2'b10)         state_next = DOWN;
    else                                  state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  assign moving = (state == UP) || (state == DOWN);

`ifdef PADDLE_ACCEL_EN
  localparam int ACW = $clog2(ACCEL_TICKS + 1);
  logic [ACW-1:0] accel_cnt;

  // Any state change (including UP<->DOWN via IDLE) restarts the acceleration run.
  always_ff @(posedge clk) begin
    if (!reset)
      accel_cnt <= '0;
    else if (state_next != state || !moving)
      accel_cnt <= '0;
    else if (tick && accel_cnt != ACW'(ACCEL_TICKS))
      accel_cnt <= accel_cnt + 1'b1;
  end

  assign step_sz = (accel_cnt == ACW'(ACCEL_TICKS)) ? 11'(2 * STEP) : 11'(STEP);
`else
  assign step_sz = 11'(STEP);
`endif

  // Both directions saturate; the down sum is one bit wider so it cannot wrap.
  assign y_up     = ({1'b0, paddle_y} < step_sz) ? 10'd0 : paddle_y - step_sz[9:0];
  assign sum_down = {1'b0, paddle_y} + step_sz;
  assign y_down   = (sum_down > 11'(MAX_Y)) ? 10'(MAX_Y) : sum_down[9:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      paddle_y <= 10'(RESET_Y);
    end else if (tick) begin
      case (state)
        UP:      paddle_y <= y_up;
        DOWN:    paddle_y <= y_down;
        default: paddle_y <= paddle_y;
      endcase
    end
  end

  assign at_top    = (paddle_y == 10'd0);
  assign at_bottom = (paddle_y == 10'(MAX_Y));

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl: scoreboard of expected positions per instance,
// popped whenever the observed paddle_y changes; directed steps in one initial block.
module tb_paddle_ctrl;

  localparam int STEP        = 4;
  localparam int MAX_Y       = 432;
  localparam int ACCEL_TICKS = 8;

  logic       clk;
  logic       reset;
  logic       btn_up, btn_down, game_over;
  logic       btn_up2, btn_down2;
  logic [9:0] paddle_y, paddle_y2;
  logic       moving, at_top, at_bottom;
  logic       moving2, at_top2, at_bottom2;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int q1[$];
  int q2[$];
  int ey1, ey2;
  int exp1, exp2;
  logic [9:0] last1, last2;
  logic mon_en = 1'b0;

  paddle_ctrl #(.CLK_DIV(4), .DEBOUNCE_CYCLES(3), .STEP(STEP)) u_dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .game_over(game_over), .paddle_y(paddle_y), .moving(moving),
    .at_top(at_top), .at_bottom(at_bottom)
  );

  paddle_ctrl #(.CLK_DIV(4), .DEBOUNCE_CYCLES(3), .STEP(STEP), .RESET_Y(214)) u_dut2 (
    .clk(clk), .reset(reset), .btn_up(btn_up2), .btn_down(btn_down2),
    .game_over(game_over), .paddle_y(paddle_y2), .moving(moving2),
    .at_top(at_top2), .at_bottom(at_bottom2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clocks since reset release; position moves land on edges where cyc % 4 == 0.
  always @(posedge clk) cyc <= (!reset) ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int step_y(input int y, input int dir, input int k);
    int s;
    s = STEP;
`ifdef PADDLE_ACCEL_EN
    if (k >= ACCEL_TICKS) s = 2 * STEP;
`endif
    if (dir > 0) return (y + s > MAX_Y) ? MAX_Y : y + s;
    else         return (y < s) ? 0 : y - s;
  endfunction

  // Queue the positions of an n-tick move run, stopping once the clamp holds it.
  task automatic push_run(input int which, input int dir, input int n);
    int y;
    int ny;
    y = (which == 1) ? ey1 : ey2;
    for (int k = 0; k < n; k++) begin
      ny = step_y(y, dir, k);
      if (ny == y) break;
      if (which == 1) q1.push_back(ny);
      else            q2.push_back(ny);
      y = ny;
    end
    if (which == 1) ey1 = y;
    else            ey2 = y;
  endtask

  task automatic push_val(input int which, input int v);
    if (which == 1) begin q1.push_back(v); ey1 = v; end
    else            begin q2.push_back(v); ey2 = v; end
  endtask

  task automatic wait_empty(input int which, input int budget, input string tag);
    int left;
    left = (which == 1) ? q1.size() : q2.size();
    for (int i = 0; i < budget && left != 0; i++) begin
      @(negedge clk);
      #1;
      left = (which == 1) ? q1.size() : q2.size();
    end
    if (left != 0) check({"timeout_", tag}, left, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && paddle_y !== last1) begin
      if (q1.size() == 0) begin
        check("unexpected_move1", 32'(paddle_y), 32'(last1));
      end else begin
        exp1 = q1.pop_front();
        check("move1", 32'(paddle_y), exp1);
        check("tick_align1", cyc % 4, 0);
      end
      last1 = paddle_y;
    end
  end

  always @(negedge clk) begin
    if (mon_en && paddle_y2 !== last2) begin
      if (q2.size() == 0) begin
        check("unexpected_move2", 32'(paddle_y2), 32'(last2));
      end else begin
        exp2 = q2.pop_front();
        check("move2", 32'(paddle_y2), exp2);
        check("tick_align2", cyc % 4, 0);
      end
      last2 = paddle_y2;
    end
  end

  initial begin
    reset = 1'b0; btn_up = 1'b0; btn_down = 1'b0; game_over = 1'b0;
    btn_up2 = 1'b0; btn_down2 = 1'b0;

    // 1: reset state and idle hold
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_y", 32'(paddle_y), 216);
    check("rst_moving", 32'(moving), 0);
    check("rst_at_top", 32'(at_top), 0);
    check("rst_at_bottom", 32'(at_bottom), 0);
    check("rst_y2", 32'(paddle_y2), 214);
    ey1 = 216; ey2 = 214; last1 = 10'd216; last2 = 10'd214;
    mon_en = 1'b1;
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_hold_y", 32'(paddle_y), 216);

    // 2: glitch rejected, then held press moves up
    btn_up = 1'b1;
    repeat (2) @(negedge clk);
    btn_up = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_moving", 32'(moving), 0);
    check("glitch_y", 32'(paddle_y), 216);
    push_run(1, -1, 5);
    btn_up = 1'b1;
    repeat (4) @(negedge clk);
    check("press_latency_4", 32'(moving), 0);
    @(negedge clk);
    check("press_latency_5", 32'(moving), 1);
    wait_empty(1, 200, "up_run");
    game_over = 1'b1;
    btn_up = 1'b0;
    @(negedge clk);
    check("freeze_moving", 32'(moving), 0);
    repeat (8) @(negedge clk);
    game_over = 1'b0;
    repeat (4) @(negedge clk);

    // 3: second instance from 214 clamps at 0
    push_run(2, -1, 1000);
    btn_up2 = 1'b1;
    wait_empty(2, 600, "top_clamp");
    repeat (40) @(negedge clk);
    check("top_y", 32'(paddle_y2), 0);
    check("top_at_top", 32'(at_top2), 1);
    check("top_at_bottom", 32'(at_bottom2), 0);
    btn_up2 = 1'b0;
    repeat (8) @(negedge clk);

    // 4: recentre, then clamp at MAX_Y
    push_val(1, 216);
    push_val(2, 214);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    push_run(1, 1, 1000);
    btn_down = 1'b1;
    wait_empty(1, 800, "bottom_clamp");
    repeat (40) @(negedge clk);
    check("bottom_y", 32'(paddle_y), MAX_Y);
    check("bottom_at_bottom", 32'(at_bottom), 1);
    check("bottom_at_top", 32'(at_top), 0);
    check("bottom_moving", 32'(moving), 1);
    btn_down = 1'b0;
    repeat (8) @(negedge clk);
    check("release_moving", 32'(moving), 0);

    // 5: both buttons hold; game_over freezes mid-UP and releases
    btn_up = 1'b1; btn_down = 1'b1;
    repeat (30) @(negedge clk);
    check("both_moving", 32'(moving), 0);
    check("both_y", 32'(paddle_y), MAX_Y);
    btn_up = 1'b0; btn_down = 1'b0;
    repeat (8) @(negedge clk);
    push_run(1, -1, 3);
    btn_up = 1'b1;
    wait_empty(1, 200, "pre_freeze");
    game_over = 1'b1;
    @(negedge clk);
    check("frozen_moving", 32'(moving), 0);
    repeat (20) @(negedge clk);
    check("frozen_y", 32'(paddle_y), ey1);
    push_run(1, -1, 2);
    game_over = 1'b0;
    @(negedge clk);
    check("unfreeze_idle", 32'(moving), 0);
    @(negedge clk);
    check("unfreeze_up", 32'(moving), 1);
    wait_empty(1, 200, "resume");
    game_over = 1'b1;
    btn_up = 1'b0;
    repeat (8) @(negedge clk);
    game_over = 1'b0;
    repeat (4) @(negedge clk);

    // 6: reset mid-DOWN recentres and forces a re-debounce
    push_val(1, 216);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    push_run(1, 1, 21);
    btn_down = 1'b1;
    wait_empty(1, 300, "down_run");
    check("pre_reset_y", 32'(paddle_y), ey1);
    push_val(1, 216);
    reset = 1'b0;
    @(negedge clk);
    check("mid_reset_y", 32'(paddle_y), 216);
    check("mid_reset_moving", 32'(moving), 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("redebounce_4", 32'(moving), 0);
    @(negedge clk);
    check("redebounce_5", 32'(moving), 1);
    push_run(1, 1, 3);
    wait_empty(1, 200, "post_reset_run");
    game_over = 1'b1;
    btn_down = 1'b0;
    repeat (8) @(negedge clk);
    game_over = 1'b0;
    repeat (8) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
